// File: rtl/vc_regfile_pkg.sv
// vc_regfile_pkg: shared state encoding and width helpers for the scrubbing register files.
package vc_regfile_pkg;
  typedef enum logic {
    SCRUB_IDLE   = 1'b0,
    SCRUB_ACTIVE = 1'b1
  } scrub_state_e;
  function automatic int addr_nbits(input int num_entries);
    return (num_entries <= 2) ? 1 : $clog2(num_entries);
  endfunction
  function automatic int slice_lo(input int k, input int nbits);
    return k * nbits;
  endfunction
  function automatic int packed_nbits(input int num_ports, input int nbits);
    return num_ports * nbits;
  endfunction
endpackage

// File: rtl/vc_regfile_scrub_ctrl.sv
// vc_regfile_scrub_ctrl: scrub FSM walking an index over every entry, one per cycle.
import vc_regfile_pkg::*;
module vc_regfile_scrub_ctrl #(
  parameter int p_num_entries = 8,
  localparam int c_addr_nbits = addr_nbits(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scrub_req,
  output logic                    scrub_busy,
  output logic                    scrub_done,
  output logic [c_addr_nbits-1:0] scrub_idx,
  output logic                    scrub_we
);
  localparam logic [c_addr_nbits-1:0] c_last = c_addr_nbits'(p_num_entries - 1);
  scrub_state_e              r_state;
  logic [c_addr_nbits-1:0]   r_idx;
  logic                      r_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCRUB_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == SCRUB_IDLE) begin
        if (scrub_req) r_state <= SCRUB_ACTIVE;
      end else if (r_idx == c_last) begin
        r_state <= SCRUB_IDLE;
        r_idx   <= '0;
        r_done  <= 1'b1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
  assign scrub_busy = (r_state == SCRUB_ACTIVE);
  assign scrub_we   = (r_state == SCRUB_ACTIVE);
  assign scrub_done = r_done;
  assign scrub_idx  = r_idx;
endmodule

// File: rtl/vc_scrub_regfile_nr2w.sv
// vc_scrub_regfile_nr2w: N-read/2-write register file with a sequential scrub engine.
// Optional write-to-read bypass under macro VC_SCRUB_REGFILE_BYPASS_EN.
import vc_regfile_pkg::*;
module vc_scrub_regfile_nr2w #(
  parameter int                  p_data_nbits  = 32,
  parameter int                  p_num_entries = 8,
  parameter int                  p_num_rports  = 2,
  parameter logic [p_data_nbits-1:0] p_reset_value = '0,
  localparam int c_addr_nbits = addr_nbits(p_num_entries)
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [packed_nbits(p_num_rports, c_addr_nbits)-1:0]   read_addr,
  output logic [packed_nbits(p_num_rports, p_data_nbits)-1:0]   read_data,
  input  logic                                                  write_en0,
  input  logic [c_addr_nbits-1:0]                               write_addr0,
  input  logic [p_data_nbits-1:0]                               write_data0,
  input  logic                                                  write_en1,
  input  logic [c_addr_nbits-1:0]                               write_addr1,
  input  logic [p_data_nbits-1:0]                               write_data1,
  output logic                                                  write_ready,
  input  logic                                                  scrub_req,
  output logic                                                  scrub_busy,
  output logic                                                  scrub_done
);
  localparam int c_depth = 1 << c_addr_nbits;
  // One bit per encodable address; set only for addresses backed by an entry.
  localparam logic [c_depth-1:0] c_valid = {c_depth{1'b1}} >> (c_depth - p_num_entries);
  logic [p_data_nbits-1:0] r_mem [p_num_entries];
  logic                    w_busy;
  logic                    w_scrub_we;
  logic [c_addr_nbits-1:0] w_scrub_idx;
  logic                    w_wen0;
  logic                    w_wen1;
  vc_regfile_scrub_ctrl #(.p_num_entries(p_num_entries)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .scrub_req  (scrub_req),
    .scrub_busy (w_busy),
    .scrub_done (scrub_done),
    .scrub_idx  (w_scrub_idx),
    .scrub_we   (w_scrub_we)
  );
  assign w_wen0      = write_en0 && !w_busy && c_valid[write_addr0];
  assign w_wen1      = write_en1 && !w_busy && c_valid[write_addr1];
  assign write_ready = !w_busy;
  assign scrub_busy  = w_busy;
  // Port 1 is applied last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) r_mem[i] <= p_reset_value;
    end else if (w_scrub_we) begin
      r_mem[w_scrub_idx] <= p_reset_value;
    end else begin
      if (w_wen0) r_mem[write_addr0] <= write_data0;
      if (w_wen1) r_mem[write_addr1] <= write_data1;
    end
  end
  for (genvar k = 0; k < p_num_rports; k++) begin : g_rport
    logic [c_addr_nbits-1:0] w_addr;
    logic [p_data_nbits-1:0] w_stored;
    logic [p_data_nbits-1:0] w_data;
    assign w_addr   = read_addr[slice_lo(k, c_addr_nbits) +: c_addr_nbits];
    assign w_stored = c_valid[w_addr] ? r_mem[w_addr] : p_reset_value;
`ifdef VC_SCRUB_REGFILE_BYPASS_EN
    assign w_data = w_busy ? p_reset_value
                  : (w_wen1 && write_addr1 == w_addr) ? write_data1
                  : (w_wen0 && write_addr0 == w_addr) ? write_data0
                  : w_stored;
`else
    assign w_data = w_busy ? p_reset_value : w_stored;
`endif
    assign read_data[slice_lo(k, p_data_nbits) +: p_data_nbits] = w_data;
  end
endmodule

// File: tb/tb_vc_scrub_regfile_nr2w.sv
// tb_vc_scrub_regfile_nr2w: directed stimulus with a per-cycle expectation queue checked by a monitor.
module tb_vc_scrub_regfile_nr2w;
  localparam int W = 32, N = 8, R = 2, A = 3;
`ifdef VC_SCRUB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic           clk = 1'b0, reset = 1'b1;
  logic [R*A-1:0] read_addr = '0;
  logic [R*W-1:0] read_data;
  logic           write_en0 = 1'b0, write_en1 = 1'b0;
  logic [A-1:0]   write_addr0 = '0, write_addr1 = '0;
  logic [W-1:0]   write_data0 = '0, write_data1 = '0;
  logic           write_ready, scrub_req = 1'b0, scrub_busy, scrub_done;
  vc_scrub_regfile_nr2w #(
    .p_data_nbits(W), .p_num_entries(N), .p_num_rports(R), .p_reset_value('0)
  ) dut (
    .clk(clk), .reset(reset), .read_addr(read_addr), .read_data(read_data),
    .write_en0(write_en0), .write_addr0(write_addr0), .write_data0(write_data0),
    .write_en1(write_en1), .write_addr1(write_addr1), .write_data1(write_data1),
    .write_ready(write_ready), .scrub_req(scrub_req), .scrub_busy(scrub_busy),
    .scrub_done(scrub_done)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; int sel; logic [W-1:0] exp; string name;} chk_t;
  chk_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [W-1:0] actual(input int sel);
    case (sel)
      0: return read_data[W-1:0];
      1: return read_data[2*W-1:W];
      2: return W'(write_ready);
      3: return W'(scrub_busy);
      default: return W'(scrub_done);
    endcase
  endfunction
  always @(negedge clk) begin
    chk_t c;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      c = q.pop_front();
      n_chk++;
      if (c.cyc != cyc || actual(c.sel) !== c.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", c.name, c.cyc, actual(c.sel), c.exp);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input int sel, input logic [W-1:0] e, input string n);
    q.push_back('{cyc, sel, e, n});
  endtask
  task automatic rd(input int a0, input int a1);
    read_addr = {A'(a1), A'(a0)};
  endtask
  task automatic wr(input logic e0, input int a0, input logic [W-1:0] d0,
                    input logic e1, input int a1, input logic [W-1:0] d1);
    write_en0 = e0; write_addr0 = A'(a0); write_data0 = d0;
    write_en1 = e1; write_addr1 = A'(a1); write_data1 = d1;
  endtask
  task automatic stat(input logic rdy, input logic busy, input logic done, input string n);
    ex(2, W'(rdy), {n, " write_ready"});
    ex(3, W'(busy), {n, " scrub_busy"});
    ex(4, W'(done), {n, " scrub_done"});
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    rd(0, 7);
    ex(0, 0, "reset rd0"); ex(1, 0, "reset rd1");
    stat(1, 0, 0, "reset");
    wr(1, 3, 32'hAAAA, 1, 3, 32'h5555);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(3, 2);
    ex(0, 32'h5555, "same-addr port1 wins"); ex(1, 0, "same-addr neighbour");
    step();
    for (int i = 0; i < N; i += 2) begin
      wr(1, i, 32'h11 * (i + 1), 1, i + 1, 32'h11 * (i + 2));
      step();
    end
    wr(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i += 2) begin
      rd(i, i + 1);
      ex(0, 32'h11 * (i + 1), "fill rd0"); ex(1, 32'h11 * (i + 2), "fill rd1");
      step();
    end
    wr(1, 1, 32'h1234, 0, 0, 0);
    rd(1, 0);
    ex(0, BYP ? 32'h1234 : 32'h22, "bypass same cycle");
    step();
    wr(0, 0, 0, 0, 0, 0);
    ex(0, 32'h1234, "write visible next cycle"); ex(1, 32'h11, "entry0 untouched");
    step();
    // Scrub with a write in the request cycle, a dropped write and an ignored re-request.
    scrub_req = 1'b1;
    wr(1, 4, 32'h77, 0, 0, 0);
    rd(0, 7);
    stat(1, 0, 0, "scrub t");
    ex(0, 32'h11, "scrub t rd0"); ex(1, 32'h88, "scrub t rd1");
    step();
    for (int j = 1; j <= N; j++) begin
      scrub_req = (j == 5);
      wr(j == 3, 2, 32'hDEAD, 0, 0, 0);
      rd(j == 3 ? 2 : 0, 7);
      stat(0, 1, 0, "scrubbing");
      ex(0, 0, "scrubbing rd0"); ex(1, 0, "scrubbing rd1");
      step();
    end
    scrub_req = 1'b0;
    wr(0, 0, 0, 0, 0, 0);
    stat(1, 0, 1, "scrub t+9");
    step();
    stat(1, 0, 0, "scrub t+10");
    for (int i = 0; i < N; i += 2) begin
      rd(i, i + 1);
      ex(0, 0, "post-scrub rd0"); ex(1, 0, "post-scrub rd1");
      step();
    end
    wr(1, 6, 32'h66, 0, 0, 0);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(6, 5);
    ex(0, 32'h66, "pre-reset fill");
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      reset = (j == 4);
      ex(3, 1, "busy before reset");
      step();
    end
    reset = 1'b0;
    stat(1, 0, 0, "after mid-scrub reset");
    ex(0, 0, "reset cleared entry6"); ex(1, 0, "reset entry5");
    wr(1, 5, 32'hBEEF, 0, 0, 0);
    step();
    wr(0, 0, 0, 0, 0, 0);
    ex(1, 32'hBEEF, "write after reset commits");
    for (int j = 0; j < 5; j++) begin
      stat(1, 0, 0, "no done after reset");
      step();
    end
    scrub_req = 1'b1;
    stat(1, 0, 0, "continuous t");
    step();
    for (int j = 1; j <= 19; j++) begin
      scrub_req = (j < 10);
      stat(!((j >= 1 && j <= 8) || (j >= 10 && j <= 17)),
           (j >= 1 && j <= 8) || (j >= 10 && j <= 17),
           (j == 9 || j == 18), "continuous");
      step();
    end
    step();
    if (q.size() != 0) begin
      n_fail += q.size();
      $display("FAIL queue drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
